// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file and write scoreboard for the execute stage. It supplies
//   the signed ALU operands on two combinational read ports and takes the
//   ALU result on one write-back port. A per-register busy bit marks each
//   register that has a write still pending. Issue is held off while a
//   source or destination register is busy (RAW/WAW hazards).
//   R0 is hardwired to zero. Writes to R0 are ignored, and R0 is never busy.
//
// Optional feature (macro REGFILE_WB_BYPASS_EN):
//   Forwards a same-cycle write-back to the read ports. It also hides that
//   register's busy bit from issue_ready, so a dependent op can issue in the
//   write-back cycle.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset          synchronous, active-high reset
//   rs1_addr/data  read port 1 (operand A), combinational
//   rs2_addr/data  read port 2 (operand B), combinational
//   issue_valid    decode wants to issue an op (rs1, rs2 -> issue_rd)
//   issue_rd       destination register of the issuing op
//   issue_ready    no hazard on rs1/rs2/issue_rd this cycle
//   wb_valid       write-back of an ALU result this cycle
//   wb_rd/wb_data  write-back destination and value
//   busy_mask      registered scoreboard, bit i = write pending on Ri
//   wb_unexpected  one-cycle pulse after a write to a non-busy, nonzero reg
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [DATA_W-1:0]   rs2_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_unexpected
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_eff;
  logic                wb_en;
  logic                issue_fire;

  assign wb_en      = wb_valid && (wb_rd != '0);
  assign issue_fire = issue_valid && issue_ready;
  assign busy_mask  = busy;

  // Read ports. R0 is forced to zero here rather than relying on its storage.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_en && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wb_en && (wb_rd == rs2_addr)) rs2_data = wb_data;
`endif
  end

  // Busy view used for the hazard check. With bypass, the register being
  // written back this cycle is already resolved.
  always_comb begin
    busy_eff    = busy;
    busy_eff[0] = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_en) busy_eff[wb_rd] = 1'b0;
`endif
  end

  assign issue_ready = !(busy_eff[rs1_addr] | busy_eff[rs2_addr] | busy_eff[issue_rd]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy          <= '0;
      wb_unexpected <= 1'b0;
    end else begin
      wb_unexpected <= wb_en && !busy[wb_rd];
      if (wb_en) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      // Placed after the clear: when the same register is issued and written
      // back together, the new write is still pending, so the set wins.
      if (issue_fire && (issue_rd != '0)) busy[issue_rd] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  rs1_addr = '0, rs2_addr = '0, issue_rd = '0, wb_rd = '0;
  logic [15:0] rs1_data, rs2_data, wb_data = '0;
  logic        issue_valid = 1'b0, issue_ready, wb_valid = 1'b0;
  logic [7:0]  busy_mask;
  logic        wb_unexpected;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_mask(busy_mask), .wb_unexpected(wb_unexpected)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_reg [8];
  bit          pending [int];  // registers with an outstanding write
  bit          m_unexp = 1'b0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  initial foreach (m_reg[i]) m_reg[i] = '0;

  function automatic bit wb_hits(input logic [2:0] a);
    return BYPASS && wb_valid && wb_rd != 0 && wb_rd == a;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 0) return 16'h0;
    if (wb_hits(a)) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_blocked(input logic [2:0] a);
    return a != 0 && pending.exists(int'(a)) && !wb_hits(a);
  endfunction

  function automatic bit m_ready();
    return !(m_blocked(rs1_addr) || m_blocked(rs2_addr) || m_blocked(issue_rd));
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] b = '0;
    foreach (pending[k]) b[k] = 1'b1;
    return b;
  endfunction

  always @(posedge clk) begin
    bit fire;
    if (reset) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      pending.delete();
      m_unexp = 1'b0;
    end else begin
      fire    = issue_valid && m_ready();
      m_unexp = wb_valid && wb_rd != 0 && !pending.exists(int'(wb_rd));
      if (wb_valid && wb_rd != 0) begin
        m_reg[wb_rd] = wb_data;
        pending.delete(int'(wb_rd));
      end
      if (fire && issue_rd != 0) pending[int'(issue_rd)] = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rs1_data", 32'(rs1_data), 32'(m_read(rs1_addr)));
      check("cyc_rs2_data", 32'(rs2_data), 32'(m_read(rs2_addr)));
      check("cyc_issue_ready", 32'(issue_ready), 32'(m_ready()));
      check("cyc_busy_mask", 32'(busy_mask), 32'(m_busy()));
      check("cyc_wb_unexpected", 32'(wb_unexpected), 32'(m_unexp));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rs1_addr = 3'(i);
      rs2_addr = 3'(7 - i);
      #1;
      check("reset_rs1_zero", 32'(rs1_data), 32'h0);
      check("reset_rs2_zero", 32'(rs2_data), 32'h0);
      tick();
    end
    check("reset_busy", 32'(busy_mask), 32'h00);
    check("reset_ready", 32'(issue_ready), 32'h1);

    // Store -5 to R3. R3 is not busy, so this is an unexpected write.
    wb_valid = 1'b1; wb_rd = 3'd3; wb_data = 16'hFFFB;
    rs1_addr = 3'd3;
    #1;
    check("r3_old_same_cycle", 32'(rs1_data), BYPASS ? 32'h0000FFFB : 32'h0);
    tick();
    idle();
    #1;
    check("r3_signed", 32'($signed(rs1_data)), 32'hFFFFFFFB);
    check("unexp_pulse", 32'(wb_unexpected), 32'h1);
    tick();
    check("unexp_drop", 32'(wb_unexpected), 32'h0);

    // Positive extreme value to R7 via read port 2.
    wb_valid = 1'b1; wb_rd = 3'd7; wb_data = 16'h7FFF;
    tick();
    idle();
    rs2_addr = 3'd7;
    #1;
    check("r7_max", 32'($signed(rs2_data)), 32'd32767);

    // RAW hazard on R2.
    issue_valid = 1'b1; issue_rd = 3'd2; rs1_addr = 3'd1; rs2_addr = 3'd4;
    #1;
    check("issue_r2_ready", 32'(issue_ready), 32'h1);
    tick();
    idle();
    check("busy_r2", 32'(busy_mask), 32'h04);
    rs1_addr = 3'd2; issue_rd = 3'd1;
    #1;
    check("raw_stall", 32'(issue_ready), 32'h0);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 3'd2; wb_data = 16'd50;
    #1;
    check("wb_cycle_ready", 32'(issue_ready), BYPASS ? 32'h1 : 32'h0);
    tick();
    idle();
    #1;
    check("after_wb_ready", 32'(issue_ready), 32'h1);
    check("after_wb_r2", 32'(rs1_data), 32'd50);
    check("expected_wb_no_pulse", 32'(wb_unexpected), 32'h0);

    // Issue to R5 and write back R5 in the same cycle while R5 is busy.
    issue_valid = 1'b1; issue_rd = 3'd5; rs1_addr = 3'd0; rs2_addr = 3'd0;
    tick();
    idle();
    check("busy_r5", 32'(busy_mask), 32'h20);
    issue_valid = 1'b1; issue_rd = 3'd5;
    wb_valid = 1'b1; wb_rd = 3'd5; wb_data = 16'h0777;
    tick();
    idle();
    rs1_addr = 3'd5;
    #1;
    // Without bypass, the WAW stall blocks the issue, so only the clear happens.
    check("same_cycle_busy5", 32'(busy_mask[5]), BYPASS ? 32'h1 : 32'h0);
    check("same_cycle_r5", 32'(rs1_data), 32'h0777);
    check("same_cycle_no_pulse", 32'(wb_unexpected), 32'h0);

    // R0 write and issue are both ignored.
    rs1_addr = 3'd0; rs2_addr = 3'd0;
    wb_valid = 1'b1; wb_rd = 3'd0; wb_data = 16'h1234;
    issue_valid = 1'b1; issue_rd = 3'd0;
    tick();
    idle();
    #1;
    check("r0_zero", 32'(rs1_data), 32'h0);
    check("r0_not_busy", 32'(busy_mask[0]), 32'h0);
    check("r0_no_pulse", 32'(wb_unexpected), 32'h0);

    // Make R2 and R3 busy, then reset with a write-back in flight.
    issue_valid = 1'b1; issue_rd = 3'd2;
    tick();
    issue_rd = 3'd3;
    tick();
    idle();
    check("busy_r2_r3", 32'(busy_mask[3:2]), 32'h3);
    reset = 1'b1; wb_valid = 1'b1; wb_rd = 3'd4; wb_data = 16'd99;
    tick();
    reset = 1'b0;
    idle();
    check("rst_busy_clear", 32'(busy_mask), 32'h00);
    check("rst_no_pulse", 32'(wb_unexpected), 32'h0);
    for (int i = 1; i < 8; i++) begin
      rs1_addr = 3'(i);
      #1;
      check("rst_regs_zero", 32'(rs1_data), 32'h0);
    end
    tick();

`ifdef REGFILE_WB_BYPASS_EN
    issue_valid = 1'b1; issue_rd = 3'd6; rs1_addr = 3'd0; rs2_addr = 3'd0;
    tick();
    idle();
    wb_valid = 1'b1; wb_rd = 3'd6; wb_data = 16'd30;
    rs2_addr = 3'd6; issue_rd = 3'd0;
    #1;
    check("bypass_rs2", 32'(rs2_data), 32'd30);
    check("bypass_ready", 32'(issue_ready), 32'h1);
    tick();
    idle();
`endif

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
